// File: rtl/cos_range_reducer_pkg.sv
// Shared Q5.11 constants and FSM state encoding for the cosine argument path.
// Reused by the range reducer, the downstream datapath and the benches.
package cos_pkg;

    localparam int W        = 16;
    localparam int FRAC     = 11;
    localparam int INT_BITS = 5;
    localparam int MAG_W    = W + 1;

    localparam logic [W-1:0] PI_Q      = 16'h1922;
    localparam logic [W-1:0] TWO_PI_Q  = 16'h3244;
    localparam logic [W-1:0] HALF_PI_Q = 16'h0C91;

    // Magnitude-width copies so comparisons against the 17-bit |x| stay unsigned.
    localparam logic [MAG_W-1:0] MAG_PI      = {1'b0, PI_Q};
    localparam logic [MAG_W-1:0] MAG_TWO_PI  = {1'b0, TWO_PI_Q};
    localparam logic [MAG_W-1:0] MAG_HALF_PI = {1'b0, HALF_PI_Q};

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRAP      = 3'd1,
        FOLD_PI   = 3'd2,
        FOLD_HALF = 3'd3,
        OUT       = 3'd4
    } state_e;

endpackage

// File: rtl/cos_range_reducer_q_neg_sat.sv
// Saturating two's-complement negate: the most negative code maps to the
// most positive one instead of wrapping back onto itself.
module q_neg_sat #(
    parameter int W = 16
) (
    input  logic [W-1:0] a_i,
    output logic [W-1:0] y_o
);

    logic [W-1:0] min_s;

    assign min_s = {1'b1, {(W-1){1'b0}}};
    assign y_o   = (a_i == min_s) ? ~min_s : ({W{1'b0}} - a_i);

endmodule

// File: rtl/cos_range_reducer.sv
// Folds a signed Q5.11 angle into [0, pi/2] and conditionally negates the
// speed so that v_out*cos(x_out) equals v_in*cos(x_in).
module cos_range_reducer
    import cos_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x_in,
    input  logic [W-1:0] v_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] x_out,
    output logic [W-1:0] v_out
);

    state_e             state_q, state_d;
    logic [MAG_W-1:0]   mag_q, mag_d;
    logic [W-1:0]       vr_q, vr_d;
    logic               neg_q, neg_d;
    logic [W-1:0]       x_q, x_d;
    logic [W-1:0]       v_q, v_d;
    logic [W-1:0]       vr_neg_s;
    logic [MAG_W-1:0]   x_abs_s;

    // |x| needs the extra bit: |0x8000| = 32768.
    assign x_abs_s = x_in[W-1] ? ({MAG_W{1'b0}} - {x_in[W-1], x_in}) : {1'b0, x_in};

    q_neg_sat #(.W(W)) u_neg (
        .a_i (vr_q),
        .y_o (vr_neg_s)
    );

    // State, working magnitude and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mag_q   <= {MAG_W{1'b0}};
            vr_q    <= {W{1'b0}};
            neg_q   <= 1'b0;
            x_q     <= {W{1'b0}};
            v_q     <= {W{1'b0}};
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            vr_q    <= vr_d;
            neg_q   <= neg_d;
            x_q     <= x_d;
            v_q     <= v_d;
        end
    end

    // Next-state and datapath: one 2*pi subtraction per WRAP cycle, then two folds.
    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        vr_d    = vr_q;
        neg_d   = neg_q;
        x_d     = x_q;
        v_d     = v_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mag_d   = x_abs_s;
                    vr_d    = v_in;
                    neg_d   = 1'b0;
                    state_d = WRAP;
                end else begin
                    state_d = IDLE;
                end
            end
            WRAP: begin
                if (mag_q >= MAG_TWO_PI) begin
                    mag_d   = mag_q - MAG_TWO_PI;
                    state_d = WRAP;
                end else begin
                    state_d = FOLD_PI;
                end
            end
            FOLD_PI: begin
                if (mag_q > MAG_PI) begin
                    mag_d = MAG_TWO_PI - mag_q;
                end else begin
                    mag_d = mag_q;
                end
                state_d = FOLD_HALF;
            end
            FOLD_HALF: begin
                // cos(pi - a) = -cos(a): the sign moves onto the speed.
                if (mag_q > MAG_HALF_PI) begin
                    mag_d = MAG_PI - mag_q;
                    neg_d = 1'b1;
                end else begin
                    mag_d = mag_q;
                end
                x_d     = mag_d[W-1:0];
                v_d     = neg_d ? vr_neg_s : vr_q;
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign x_out     = x_q;
    assign v_out     = v_q;

endmodule

// File: doc/cos_range_reducer.md
Name: cos_range_reducer

Overview:
Upstream argument-conditioning stage for the cosine controlUnit/datapath pair. It accepts an arbitrary signed Q5.11 angle x and speed v. It folds x into [0, π/2] and negates v where needed, so that v_out·cos(x_out) = v·cos(x). The Taylor series in the datapath then only ever sees small arguments. Outputs drive XSig/vSig, and out_valid is suitable as the downstream start.

Parameters:
W, 16, data width (signed Q5.11: 5 integer bits incl. sign, 11 fraction bits)
PI_Q, 16'h1922, π in Q5.11 (6434)
TWO_PI_Q, 16'h3244, 2π in Q5.11 (12868)
HALF_PI_Q, 16'h0C91, π/2 in Q5.11 (3217)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  x_in/v_in valid
in_ready  out  1  block can accept (high only in IDLE)
x_in  in  W  signed Q5.11 angle, radians
v_in  in  W  signed Q5.11 speed
out_valid  out  1  reduced pair available
out_ready  in  1  consumer accepts
x_out  out  W  reduced angle, 0 ≤ x_out ≤ HALF_PI_Q, MSB always 0
v_out  out  W  v_in or saturated −v_in

Behaviour:
- Reset (async, any state): state=IDLE, mag=0, vr=0, neg=0, out_valid=0, x_out=0, v_out=0, in_ready=1. Handshakes while rst=1 are ignored.
- in_ready = (state==IDLE). out_valid = (state==OUT). x_out/v_out are registered and stable while out_valid=1.
- Internal magnitude mag is 17-bit unsigned, so |0x8000| = 32768 has no overflow.
- IDLE: on an edge with in_valid & in_ready:
  - mag ← |x_in| (cos is even)
  - vr ← v_in, neg ← 0
  - go to WRAP
- WRAP: if mag ≥ TWO_PI_Q, then mag ← mag − TWO_PI_Q and stay; otherwise go to FOLD_PI. One subtraction per cycle, k ≤ 2 for any 16-bit input.
- FOLD_PI: if mag > PI_Q, then mag ← TWO_PI_Q − mag. Go to FOLD_HALF.
- FOLD_HALF: if mag > HALF_PI_Q, then mag ← PI_Q − mag and neg ← 1. Go to OUT, registering:
  - x_out ← mag[W-1:0]
  - v_out ← neg ? sat(−vr) : vr, where sat(−0x8000) = 0x7FFF
- OUT: hold outputs. On out_ready go to IDLE (out_valid falls after that edge). No new input is accepted in the same cycle.
- Latency: out_valid is high after the (3+k)-th rising edge following the accept edge, where k is the number of 2π subtractions.
- Throughput: one result per (5+k) cycles minimum.
- Boundaries (comparisons strict except WRAP's ≥):
  - mag exactly 2π → subtracted to 0
  - mag exactly π → no fold in FOLD_PI
  - mag exactly π/2 → no fold, neg=0
  - x_in=0 → x_out=0
- x_in/v_in changes outside an accept edge have no effect. Inputs are sampled only at the handshake.
- out_ready held high continuously is legal. out_ready low holds OUT indefinitely.

Decomposition:
- Shared package cos_pkg:
  - Q5.11 width/fraction constants
  - PI_Q, TWO_PI_Q, HALF_PI_Q
  - state enum {IDLE, WRAP, FOLD_PI, FOLD_HALF, OUT}
  - These are reused by the datapath and benches.
- One natural sub-module: q_neg_sat (combinational saturating two's-complement negate, W bits). It is also reusable in the datapath.
- Everything else stays in one FSM+datapath module.

Test Plan:
1. x_in=0x0400 (0.5), v_in=0x0800 (1.0), out_ready=1 → x_out=0x0400, v_out=0x0800, out_valid after 3rd edge (k=0).
2. x_in=0x1922 (π), v_in=0xF400 (−1.5) → FOLD_HALF folds: x_out=0x0000, v_out=0x0C00, latency 3.
3. x_in=0xC800 (−7.0), v_in=0x0800 → one 2π subtraction: x_out=0x05BC, v_out=0x0800, latency 4.
4. x_in=0x8000 (−16.0), v_in=0x8000 → k=2; WRAP 32768→19900→7032; FOLD_PI → 5836; FOLD_HALF → 598. Result x_out=0x0256, v_out=0x7FFF (saturated), latency 5.
5. Case 1 with out_ready=0 for 6 cycles, in_valid=1 with x_in changing → out_valid and outputs held constant, in_ready=0, no second accept. Release: out_valid drops after the handshake edge, in_ready=1 next cycle.
6. Case 4 with rst pulsed during the second WRAP cycle → out_valid=0 and outputs=0 immediately (asynchronous), in_ready=1. A subsequent case-1 transaction completes correctly.
